text_console_ctrl: RTL
======================

# text_console_ctrl

Write-side controller for the 80x30 text tile RAM that the font/tile display path reads. Accepts a stream of 7-bit character codes over a valid/ready handshake and sequences all writes into the tile RAM write port: printable characters at the cursor, control codes (CR, LF, BS, FF), and bulk clear fills. It owns the cursor position, which the display path uses for the reverse-video cursor overlay. It sits between a character source (UART, keyboard, or switch/button front end) and the dual-port video RAM.

## Interface
- MAX_X, 80, columns per row (cursor x range 0..MAX_X-1)
- MAX_Y, 30, rows per screen (cursor y range 0..MAX_Y-1)
- FILL_CHAR, 7'h20, code written by clears and backspace erase
- One clock; reset is synchronous and active-high.
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- char_valid  in  1  char_data is presented
- char_data  in  7  character code; held stable while char_valid=1 and char_ready=0
- char_ready  out  1  controller accepts char_data this cycle
- we  out  1  tile RAM write enable, registered
- addr_w  out  12  tile RAM write address {y[4:0], x[6:0]}, registered
- din  out  7  tile RAM write data, registered
- cur_x  out  7  cursor column
- cur_y  out  5  cursor row

## Operation
- Transfer occurs on a rising edge where char_valid & char_ready. char_valid without char_ready is not consumed.
- States:
  - IDLE: char_ready=1.
  - CLEAR_SCREEN: char_ready=0. One write per cycle. Addresses run row-major (0,0)..(MAX_Y-1,MAX_X-1) with din=FILL_CHAR. Goes to IDLE after the last write.
  - CLEAR_LINE: char_ready=0. MAX_X writes to (row, 0..MAX_X-1) with din=FILL_CHAR, then IDLE.
- Code handling, for each accepted character:
  - 0x20-0x7E: write the code at (cur_y,cur_x), then x+1. At x=MAX_X-1: x=0 and y+1.
  - 0x0D CR: x=0. No write.
  - 0x0A LF: y+1, x unchanged. No write.
  - 0x08 BS: if x>0, x-1 and write FILL_CHAR at the new position. If x=0, no effect.
  - 0x0C FF: cursor set to (0,0), then CLEAR_SCREEN.
  - All other codes are consumed and ignored.
- Row increment at y=MAX_Y-1 wraps to y=0. There is no scrolling.
- Arithmetic: x and y compare against MAX_X-1 and MAX_Y-1 exactly and never hold an out-of-range value. addr_w is the concatenation {y,x}; no multiply.

## Timing
- Reset (cycle with reset=1):
  - Outputs: we=0, addr_w=0, din=0, char_ready=0, cur_x=0, cur_y=0.
  - State loads CLEAR_SCREEN with the fill counter at 0.
- After reset: the first fill write appears in the cycle after the first edge with reset=0. There are MAX_X*MAX_Y (2400) consecutive we=1 cycles, and char_ready rises in the cycle after the last write.
- Accept on edge ending cycle t:
  - Printable or BS write: we=1 in cycle t+1 with the pre-move address for printable, or the post-move address for BS.
  - cur_x/cur_y updated in cycle t+1.
  - char_ready stays 1 in t+1 unless a clear is entered, so back-to-back accepts sustain one write per cycle.
- FF accepted at t:
  - char_ready=0 from t+1.
  - Fill writes in t+1..t+2400.
  - char_ready=1 in t+2401.
- reset asserted mid-clear: the clear aborts, the cursor returns to (0,0), and the full-screen clear restarts. Partial state is never preserved.
- we is never asserted in two roles in one cycle. A character write always precedes any line clear it triggers.

## Configuration
- CONSOLE_LINE_CLEAR_EN defined: any row change caused by printable wrap or LF enters CLEAR_LINE for the new row. The triggering character's write, if any, is in t+1, the line-clear writes are in t+2..t+MAX_X+1, and char_ready returns to 1 in t+MAX_X+2.
- Not defined: CLEAR_LINE is not compiled. Row changes leave old row content intact, and char_ready stays 1.

## Test plan
- Reset for 3 cycles, then release -> exactly 2400 we=1 cycles, addresses 12'h000 through {5'd29,7'd79} row-major with din=7'h20; char_ready rises in the cycle after the last write; cursor (0,0).
- Send 'A','B' back-to-back -> writes 7'h41@(0,0) and 7'h42@(0,1) in consecutive cycles; cursor (0,2); char_ready never drops.
- Cursor at (29,79), send 'Z' -> 7'h5A written @(29,79), cursor (0,0). With CONSOLE_LINE_CLEAR_EN: 80 fills of row 0 follow, and char_ready is low for 81 cycles. Without it: no fills.
- Cursor (3,5): send BS -> write 7'h20@(3,4), cursor (3,4). Cursor (3,0): send BS -> no write, cursor unchanged.
- Send CR then LF from (3,5) -> no writes (macro off), cursor (4,0). Send code 7'h01 -> consumed, no write, cursor unchanged.
- Send FF, assert reset at fill 1000 -> fill restarts from address 0; the total of 2400 writes completes after reset release; held char_valid is not consumed until char_ready=1.

Source files
------------

// File: rtl/text_console_ctrl.sv
// text_console_ctrl
// Write-side controller for the 80x30 text tile RAM. It takes 7-bit character
// codes over a valid/ready handshake, owns the cursor and sequences every
// write into the tile RAM: printable characters, backspace erase, and
// full-screen / single-line fills.
//
// Optional feature macro: CONSOLE_LINE_CLEAR_EN. When defined, any row change
// caused by a printable wrap or LF clears the new row before more input is taken.
//
// Ports
//   clk         in   system/pixel clock
//   reset       in   synchronous, active-high
//   char_valid  in   char_data is presented
//   char_data   in   [6:0] character code, held while char_valid & !char_ready
//   char_ready  out  controller accepts char_data this cycle
//   we          out  tile RAM write enable (registered)
//   addr_w      out  [11:0] tile RAM write address {y[4:0], x[6:0]} (registered)
//   din         out  [6:0] tile RAM write data (registered)
//   cur_x       out  [6:0] cursor column
//   cur_y       out  [4:0] cursor row
module text_console_ctrl #(
    parameter int         MAX_X     = 80,
    parameter int         MAX_Y     = 30,
    parameter logic [6:0] FILL_CHAR = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_data,
    output logic        char_ready,
    output logic        we,
    output logic [11:0] addr_w,
    output logic [6:0]  din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y
);

    localparam logic [6:0] X_LAST = 7'(MAX_X - 1);
    localparam logic [4:0] Y_LAST = 5'(MAX_Y - 1);

    localparam logic [6:0] C_BS = 7'h08;
    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_FF = 7'h0C;
    localparam logic [6:0] C_CR = 7'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR_SCREEN
`ifdef CONSOLE_LINE_CLEAR_EN
        , S_CLEAR_LINE
`endif
    } state_t;

    state_t     state;
    logic [6:0] fill_x;
    logic [4:0] fill_y;

    logic       accept;
    logic       is_print;
    logic       at_x_last;
    logic [4:0] next_y;
`ifdef CONSOLE_LINE_CLEAR_EN
    logic       row_chg;
`endif

    always_comb begin
        accept    = char_valid && char_ready && (state == S_IDLE);
        is_print  = (char_data >= 7'h20) && (char_data <= 7'h7E);
        at_x_last = (cur_x == X_LAST);
        next_y    = (cur_y == Y_LAST) ? 5'd0 : cur_y + 5'd1;
`ifdef CONSOLE_LINE_CLEAR_EN
        row_chg   = accept && ((is_print && at_x_last) || (char_data == C_LF));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Fill counter at 0: the first fill is issued on the first edge
            // after reset is released.
            state      <= S_CLEAR_SCREEN;
            fill_x     <= 7'd0;
            fill_y     <= 5'd0;
            we         <= 1'b0;
            addr_w     <= 12'd0;
            din        <= 7'd0;
            char_ready <= 1'b0;
            cur_x      <= 7'd0;
            cur_y      <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    we         <= 1'b0;
                    char_ready <= 1'b1;
                    if (accept) begin
                        if (is_print) begin
                            we     <= 1'b1;
                            addr_w <= {cur_y, cur_x};
                            din    <= char_data;
                            if (at_x_last) begin
                                cur_x <= 7'd0;
                                cur_y <= next_y;
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
                        end else if (char_data == C_CR) begin
                            cur_x <= 7'd0;
                        end else if (char_data == C_LF) begin
                            cur_y <= next_y;
                        end else if (char_data == C_BS) begin
                            if (cur_x != 7'd0) begin
                                cur_x  <= cur_x - 7'd1;
                                we     <= 1'b1;
                                addr_w <= {cur_y, cur_x - 7'd1};
                                din    <= FILL_CHAR;
                            end
                        end else if (char_data == C_FF) begin
                            // The first fill (0,0) is issued right here so the
                            // clear starts in the cycle after the accept.
                            cur_x      <= 7'd0;
                            cur_y      <= 5'd0;
                            we         <= 1'b1;
                            addr_w     <= 12'd0;
                            din        <= FILL_CHAR;
                            fill_x     <= 7'd1;
                            fill_y     <= 5'd0;
                            char_ready <= 1'b0;
                            state      <= S_CLEAR_SCREEN;
                        end
`ifdef CONSOLE_LINE_CLEAR_EN
                        // The character write (if any) goes out first; the
                        // line fills follow from the next cycle on.
                        if (row_chg) begin
                            fill_x     <= 7'd0;
                            char_ready <= 1'b0;
                            state      <= S_CLEAR_LINE;
                        end
`endif
                    end
                end

                S_CLEAR_SCREEN: begin
                    we         <= 1'b1;
                    addr_w     <= {fill_y, fill_x};
                    din        <= FILL_CHAR;
                    char_ready <= 1'b0;
                    if (fill_x == X_LAST) begin
                        fill_x <= 7'd0;
                        if (fill_y == Y_LAST) begin
                            fill_y <= 5'd0;
                            state  <= S_IDLE;
                        end else begin
                            fill_y <= fill_y + 5'd1;
                        end
                    end else begin
                        fill_x <= fill_x + 7'd1;
                    end
                end

`ifdef CONSOLE_LINE_CLEAR_EN
                S_CLEAR_LINE: begin
                    // cur_y already holds the new row and is stable here.
                    we         <= 1'b1;
                    addr_w     <= {cur_y, fill_x};
                    din        <= FILL_CHAR;
                    char_ready <= 1'b0;
                    if (fill_x == X_LAST) begin
                        fill_x <= 7'd0;
                        state  <= S_IDLE;
                    end else begin
                        fill_x <= fill_x + 7'd1;
                    end
                end
`endif

                default: begin
                    we         <= 1'b0;
                    char_ready <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
